// File: rtl/common.sv
// Shared basic types for the pipeline blocks.
//   u1          : single-bit flag
//   creg_addr_t : core register-file address (x0 is hard-wired zero)
package common;

    localparam int unsigned CREG_AW = 5;

    typedef logic               u1;
    typedef logic [CREG_AW-1:0] creg_addr_t;

endpackage

// File: rtl/pipes.sv
// Pipeline-control definitions: hazard FSM states and mul/div timing defaults.
package pipes;

    localparam int unsigned MULDIV_LAT_DEFAULT = 64;
    localparam int unsigned HZ_CNT_W           = 8;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MULDIV  = 2'd1,
        DISCARD = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/hazard_loaduse.sv
// Load-use hazard compare: the execute-stage load writes a register the
// decode-stage instruction reads. Purely combinational.
//   memread_E, dst_E : execute-stage load flag and destination
//   ra1_D, ra2_D     : decode-stage source registers
//   load_use_c       : hazard present this cycle
module hazard_loaduse
    import common::*;
(
    input  logic       memread_E,
    input  creg_addr_t dst_E,
    input  creg_addr_t ra1_D,
    input  creg_addr_t ra2_D,
    output logic       load_use_c
);

    // x0 never carries a real dependency
    assign load_use_c = memread_E && (dst_E != '0) &&
                        ((dst_E == ra1_D) || (dst_E == ra2_D));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stage load enables, bubble flushes, branch
// redirect select and mul/div busy, for a 5-stage in-order pipeline.
//   clk, reset        : clock, async active-high reset
//   i_wait, d_wait    : fetch / data-memory access outstanding
//   ra1_D, ra2_D      : decode source registers
//   dst_E, memread_E  : execute destination and load flag
//   branch_taken_E    : execute-stage redirect
//   muldiv_start_E    : execute-stage mul/div start
//   *_en, *_flush     : stage register load enables and bubble loads
//   redirect_sel      : pc selector takes the branch target
//   muldiv_busy       : mul/div in progress
// Outputs are combinational from state, cnt and inputs.
module hazard_ctrl
    import common::*;
    import pipes::*;
#(
    parameter int unsigned MULDIV_LAT = MULDIV_LAT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_wait,
    input  logic       d_wait,
    input  creg_addr_t ra1_D,
    input  creg_addr_t ra2_D,
    input  creg_addr_t dst_E,
    input  logic       memread_E,
    input  logic       branch_taken_E,
    input  logic       muldiv_start_E,
    output logic       pc_en,
    output logic       dreg_en,
    output logic       ereg_en,
    output logic       mreg_en,
    output logic       wreg_en,
    output logic       dreg_flush,
    output logic       ereg_flush,
    output logic       mreg_flush,
    output logic       wreg_flush,
    output logic       redirect_sel,
    output logic       muldiv_busy
);

    hazard_state_t         state_q, state_d;
    logic [HZ_CNT_W-1:0]   cnt_q, cnt_d;
    u1                     load_use;

    hazard_loaduse u_loaduse (
        .memread_E  (memread_E),
        .dst_E      (dst_E),
        .ra1_D      (ra1_D),
        .ra2_D      (ra2_D),
        .load_use_c (load_use)
    );

    // State and mul/div countdown
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Prioritised hazard response: d_wait, MULDIV, branch, load-use, i_wait
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_en        = 1'b1;
        dreg_en      = 1'b1;
        ereg_en      = 1'b1;
        mreg_en      = 1'b1;
        wreg_en      = 1'b1;
        dreg_flush   = 1'b0;
        ereg_flush   = 1'b0;
        mreg_flush   = 1'b0;
        wreg_flush   = 1'b0;
        redirect_sel = 1'b0;
        muldiv_busy  = (state_q == MULDIV);

        if (reset) begin
            pc_en       = 1'b0;
            dreg_en     = 1'b0;
            ereg_en     = 1'b0;
            mreg_en     = 1'b0;
            wreg_en     = 1'b0;
            dreg_flush  = 1'b1;
            ereg_flush  = 1'b1;
            mreg_flush  = 1'b1;
            wreg_flush  = 1'b1;
            muldiv_busy = 1'b0;
        end else if (d_wait) begin
            // Freeze everything up to memory; retire a bubble into writeback
            pc_en      = 1'b0;
            dreg_en    = 1'b0;
            ereg_en    = 1'b0;
            mreg_en    = 1'b0;
            wreg_flush = 1'b1;
        end else begin
            case (state_q)
                MULDIV: begin
                    if (cnt_q > HZ_CNT_W'(1)) begin
                        pc_en      = 1'b0;
                        dreg_en    = 1'b0;
                        ereg_en    = 1'b0;
                        mreg_flush = 1'b1;
                        cnt_d      = cnt_q - HZ_CNT_W'(1);
                    end else begin
                        // Last cycle: result into mreg, mul/div leaves execute
                        ereg_flush = 1'b1;
                        cnt_d      = '0;
                        state_d    = RUN;
                    end
                end
                DISCARD: begin
                    // Fetch issued before the redirect is still in flight; drop it
                    dreg_flush = 1'b1;
                    pc_en      = !i_wait;
                    if (!i_wait) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    if (muldiv_start_E) begin
                        pc_en      = 1'b0;
                        dreg_en    = 1'b0;
                        ereg_en    = 1'b0;
                        mreg_flush = 1'b1;
                        cnt_d      = HZ_CNT_W'(MULDIV_LAT - 1);
                        state_d    = MULDIV;
                    end else if (branch_taken_E) begin
                        redirect_sel = 1'b1;
                        dreg_flush   = 1'b1;
                        ereg_flush   = 1'b1;
                        if (i_wait) begin
                            state_d = DISCARD;
                        end
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        dreg_en    = 1'b0;
                        ereg_flush = 1'b1;
                    end else if (i_wait) begin
                        pc_en      = 1'b0;
                        dreg_flush = 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Two instances share stimulus: one with
// a short mul/div latency (4) and one long (40) for the mid-operation reset.
// Output vectors are packed {pc,d,e,m,w en, d,e,m,w flush, redirect, busy}.
module tb_hazard_ctrl;

    localparam logic [10:0] RST_V = 11'b00000_1111_0_0;
    localparam logic [10:0] DEF_V = 11'b11111_0000_0_0;
    localparam logic [10:0] DW_V  = 11'b00001_0001_0_0;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_wait, d_wait, memread_E, branch_taken_E, muldiv_start_E;
    logic [4:0] ra1_D, ra2_D, dst_E;
    logic [10:0] oa, ob;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: remaining mul/div execute cycles and pending fetch drop
    int rem  [2];
    bit disc [2];
    int lat  [2];

    int t_busy, t_mf_busy, t_cap, t_wf, t_dfl, t_rs;
    logic [10:0] last_oa, last_ob;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULDIV_LAT(4)) dut_a (
        .clk(clk), .reset(reset), .i_wait(i_wait), .d_wait(d_wait),
        .ra1_D(ra1_D), .ra2_D(ra2_D), .dst_E(dst_E), .memread_E(memread_E),
        .branch_taken_E(branch_taken_E), .muldiv_start_E(muldiv_start_E),
        .pc_en(oa[10]), .dreg_en(oa[9]), .ereg_en(oa[8]), .mreg_en(oa[7]),
        .wreg_en(oa[6]), .dreg_flush(oa[5]), .ereg_flush(oa[4]),
        .mreg_flush(oa[3]), .wreg_flush(oa[2]), .redirect_sel(oa[1]),
        .muldiv_busy(oa[0])
    );

    hazard_ctrl #(.MULDIV_LAT(40)) dut_b (
        .clk(clk), .reset(reset), .i_wait(i_wait), .d_wait(d_wait),
        .ra1_D(ra1_D), .ra2_D(ra2_D), .dst_E(dst_E), .memread_E(memread_E),
        .branch_taken_E(branch_taken_E), .muldiv_start_E(muldiv_start_E),
        .pc_en(ob[10]), .dreg_en(ob[9]), .ereg_en(ob[8]), .mreg_en(ob[7]),
        .wreg_en(ob[6]), .dreg_flush(ob[5]), .ereg_flush(ob[4]),
        .mreg_flush(ob[3]), .wreg_flush(ob[2]), .redirect_sel(ob[1]),
        .muldiv_busy(ob[0])
    );

    function automatic logic [10:0] model_out(int k);
        logic pc, d, e, m, w, df, ef, mf, wf, rs, bz;
        logic lu;
        if (reset) return RST_V;
        {pc, d, e, m, w} = 5'b11111;
        {df, ef, mf, wf, rs} = 5'b00000;
        bz = (rem[k] > 0);
        lu = memread_E && (dst_E != 5'd0) && (dst_E == ra1_D || dst_E == ra2_D);
        if (d_wait) begin
            {pc, d, e, m} = 4'b0000;
            wf = 1'b1;
        end else if (rem[k] > 1) begin
            {pc, d, e} = 3'b000;
            mf = 1'b1;
        end else if (rem[k] == 1) begin
            ef = 1'b1;
        end else if (disc[k]) begin
            df = 1'b1;
            pc = !i_wait;
        end else if (muldiv_start_E) begin
            {pc, d, e} = 3'b000;
            mf = 1'b1;
        end else if (branch_taken_E) begin
            rs = 1'b1;
            df = 1'b1;
            ef = 1'b1;
        end else if (lu) begin
            pc = 1'b0;
            d  = 1'b0;
            ef = 1'b1;
        end else if (i_wait) begin
            pc = 1'b0;
            df = 1'b1;
        end
        return {pc, d, e, m, w, df, ef, mf, wf, rs, bz};
    endfunction

    task automatic model_tick();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                rem[k]  = 0;
                disc[k] = 1'b0;
            end else if (!d_wait) begin
                if (rem[k] > 0)               rem[k]  = rem[k] - 1;
                else if (disc[k])             disc[k] = i_wait;
                else if (muldiv_start_E)      rem[k]  = lat[k] - 1;
                else if (branch_taken_E && i_wait) disc[k] = 1'b1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_tally();
        t_busy = 0; t_mf_busy = 0; t_cap = 0; t_wf = 0; t_dfl = 0; t_rs = 0;
    endtask

    // One cycle: sample mid-cycle against the model, then advance on the edge
    task automatic cyc(input string tag);
        #3;
        last_oa = oa;
        last_ob = ob;
        check({tag, "_a"}, oa, model_out(0));
        check({tag, "_b"}, ob, model_out(1));
        t_busy    += int'(oa[0]);
        t_mf_busy += int'(oa[3] & oa[0]);
        t_cap     += int'(oa[7] & oa[0] & ~oa[3]);
        t_wf      += int'(oa[2]);
        t_dfl     += int'(oa[5]);
        t_rs      += int'(oa[1]);
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic idle();
        i_wait = 0; d_wait = 0; memread_E = 0; branch_taken_E = 0;
        muldiv_start_E = 0; ra1_D = 0; ra2_D = 0; dst_E = 0;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 60 && (rem[0] > 0 || rem[1] > 0 || disc[0] || disc[1]); i++)
            cyc("drain");
        cyc("drain_end");
        check_int("drain_idle_b", int'(last_ob[0]), 0);
    endtask

    initial begin
        lat[0] = 4; lat[1] = 40;
        rem[0] = 0; rem[1] = 0; disc[0] = 0; disc[1] = 0;
        clr_tally();
        idle();
        reset = 1'b1;

        // Reset values
        #1;
        check("reset_a", oa, RST_V);
        check("reset_b", ob, RST_V);
        cyc("rst_hold");
        reset = 1'b0;
        cyc("idle0");
        check("default_run", last_oa, DEF_V);

        // Load-use
        memread_E = 1; dst_E = 5; ra1_D = 5;
        cyc("lu_ra1");
        check("lu_stall", last_oa, 11'b00111_0100_0_0);
        dst_E = 0; ra1_D = 0;
        cyc("lu_x0");
        check("lu_x0_nostall", last_oa, DEF_V);
        dst_E = 7; ra2_D = 7; ra1_D = 3;
        cyc("lu_ra2");
        memread_E = 0;
        cyc("lu_noload");
        idle();
        cyc("idle1");

        // Mul/div, latency 4
        clr_tally();
        muldiv_start_E = 1;
        cyc("md_start");
        muldiv_start_E = 0;
        for (int i = 0; i < 4; i++) cyc("md_run");
        check_int("md_busy_cycles", t_busy, 3);
        check_int("md_mflush_busy", t_mf_busy, 2);
        check_int("md_capture", t_cap, 1);
        check("md_back_run", last_oa, DEF_V);
        drain();

        // Mul/div with d_wait at cnt=2
        clr_tally();
        muldiv_start_E = 1;
        cyc("mdw_start");
        muldiv_start_E = 0;
        cyc("mdw_cnt3");
        d_wait = 1;
        cyc("mdw_dw0");
        cyc("mdw_dw1");
        d_wait = 0;
        for (int i = 0; i < 3; i++) cyc("mdw_run");
        check_int("mdw_latency", t_busy + 1, 6);
        check_int("mdw_wflush", t_wf, 2);
        check_int("mdw_capture", t_cap, 1);
        drain();

        // Branch with fetch outstanding
        clr_tally();
        branch_taken_E = 1; i_wait = 1;
        cyc("br_take");
        branch_taken_E = 0;
        cyc("br_disc0");
        cyc("br_disc1");
        i_wait = 0;
        cyc("br_disc_end");
        cyc("br_after");
        check_int("br_redirect_once", t_rs, 1);
        check_int("br_dflush_cycles", t_dfl, 4);
        check("br_run", last_oa, DEF_V);

        // d_wait over branch and load-use
        d_wait = 1; branch_taken_E = 1; memread_E = 1; dst_E = 3; ra1_D = 3;
        cyc("dw_prio");
        check("dw_only", last_oa, DW_V);
        d_wait = 0;
        cyc("dw_drop_branch");
        check_int("dw_branch_after", int'(last_oa[1]), 1);
        idle();
        cyc("idle2");

        // Async reset mid mul/div on the long-latency instance
        muldiv_start_E = 1;
        cyc("mdr_start");
        muldiv_start_E = 0;
        for (int i = 0; i < 50 && rem[1] != 30; i++) cyc("mdr_run");
        check_int("mdr_busy_at30", int'(last_ob[0]), 1);
        #2;
        reset = 1'b1;
        #1;
        check("mdr_async_b", ob, RST_V);
        check("mdr_async_a", oa, RST_V);
        for (int k = 0; k < 2; k++) begin rem[k] = 0; disc[k] = 1'b0; end
        cyc("mdr_hold");
        reset = 1'b0;
        cyc("mdr_release");
        check("mdr_run_b", last_ob, DEF_V);

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            reset          = ($urandom_range(0, 79) == 0);
            d_wait         = ($urandom_range(0, 7) == 0);
            i_wait         = ($urandom_range(0, 3) == 0);
            muldiv_start_E = ($urandom_range(0, 15) == 0);
            branch_taken_E = ($urandom_range(0, 5) == 0);
            memread_E      = ($urandom_range(0, 2) == 0);
            dst_E          = 5'($urandom_range(0, 3));
            ra1_D          = 5'($urandom_range(0, 3));
            ra2_D          = 5'($urandom_range(0, 3));
            cyc("rand");
        end
        reset = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL take parameter MULDIV_LAT, default 64: total execute-stage cycles of a mul/div, legal range 2..255.
REQ-002 SHALL have port clk, input, 1: the single clock for the block.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port i_wait, input, 1: the instruction fetch is outstanding, and fetch data is not valid this cycle.
REQ-005 SHALL have port d_wait, input, 1: the memory-stage data access is outstanding.
REQ-006 SHALL have ports ra1_D and ra2_D, input, creg_addr_t (5): decode-stage source registers.
REQ-007 SHALL have ports dst_E (input, creg_addr_t) and memread_E (input, 1): destination and load flag of the execute-stage instruction.
REQ-008 SHALL have ports branch_taken_E and muldiv_start_E, input, 1 each: execute-stage redirect and mul/div start.
REQ-009 SHALL have outputs pc_en, dreg_en, ereg_en, mreg_en and wreg_en, 1 each: the stage register load enables.
REQ-010 SHALL have outputs dreg_flush, ereg_flush, mreg_flush and wreg_flush, 1 each: load a bubble; flush wins over hold.
REQ-011 SHALL have outputs redirect_sel (1: pc selector takes the branch target) and muldiv_busy (1).

Function
REQ-012 SHALL implement FSM states RUN, MULDIV and DISCARD, plus an 8-bit down-counter cnt.
REQ-013 SHALL in the default case (RUN, no condition active) drive every *_en=1, every *_flush=0 and redirect_sel=0.
REQ-014 SHALL evaluate priority in this order, highest first: d_wait, MULDIV, branch, load-use, i_wait.
REQ-015 SHALL on d_wait=1 in any state drive pc_en, dreg_en, ereg_en and mreg_en to 0, with wreg_en=1 and wreg_flush=1; FSM and cnt hold.
REQ-016 SHALL in RUN with muldiv_start_E=1 and d_wait=0 load cnt=MULDIV_LAT-1, go to MULDIV, hold pc/dreg/ereg and drive mreg_flush=1.
REQ-017 SHALL in MULDIV drive muldiv_busy=1 and decrement cnt each non-d_wait cycle, holding pc/dreg/ereg with mreg_flush=1 while cnt>1.
REQ-018 SHALL in MULDIV with cnt==1 drive mreg_en=1 and mreg_flush=0 to capture the result, ereg_flush=1, pc/dreg enabled, and return to RUN; MULDIV_LAT total cycles from start.
REQ-019 SHALL in RUN with branch_taken_E=1 drive redirect_sel=1, pc_en=1, dreg_flush=1 and ereg_flush=1.
REQ-020 SHALL, if i_wait=1 in that same cycle, additionally enter DISCARD.
REQ-021 SHALL in DISCARD drive dreg_flush=1 and pc_en=!i_wait, returning to RUN in the first cycle with i_wait=0; the stale fetch is dropped.
REQ-022 SHALL detect load-use as memread_E && dst_E!=0 && (dst_E==ra1_D || dst_E==ra2_D), and then drive pc_en=0, dreg_en=0 and ereg_flush=1.
REQ-023 SHALL in RUN with only i_wait=1 drive pc_en=0 and dreg_flush=1; downstream stages advance.
REQ-024 SHALL give muldiv_start_E priority if muldiv_start_E and branch_taken_E are both 1; the branch is re-evaluated when ereg releases.
REQ-025 SHALL compute outputs combinationally from state, cnt and inputs; only state and cnt are registered.

Reset
REQ-026 SHALL on reset assertion immediately force state=RUN and cnt=0, independent of clk.
REQ-027 SHALL while reset=1 drive all *_en=0, all *_flush=1, redirect_sel=0 and muldiv_busy=0.
REQ-028 SHALL, if reset arrives mid-MULDIV or mid-DISCARD, abandon the operation, with no pending redirect or result after release.

Structure
REQ-029 SHALL place the state enum hazard_state_t and the default of MULDIV_LAT in package pipes.
REQ-030 SHALL take creg_addr_t and u1 from package common.
REQ-031 SHALL be a single module with no sub-module; an optional child hazard_loaduse (combinational compare) is allowed.

Verification
REQ-032 SHALL cover load-use: memread_E=1, dst_E=5, ra1_D=5 -> one cycle pc_en=0, dreg_en=0, ereg_flush=1; with dst_E=0 -> no stall.
REQ-033 SHALL cover mul/div: MULDIV_LAT=4, muldiv_start_E pulse -> muldiv_busy=1 for 3 cycles, mreg_flush=1 for 2 cycles, mreg_en capture on cycle 3, then RUN.
REQ-034 SHALL cover branch with fetch outstanding: branch_taken_E=1 with i_wait=1 for 3 cycles -> redirect_sel=1 once, dreg_flush=1 for 4 cycles, RUN after i_wait falls.
REQ-035 SHALL cover d_wait during MULDIV: d_wait=1 for 2 cycles at cnt=2 -> cnt frozen, wreg_flush=1, total mul/div latency 6 cycles.
REQ-036 SHALL cover simultaneous d_wait, branch_taken_E and load-use -> only the d_wait response; the branch is acted on the cycle d_wait drops.
REQ-037 SHALL cover async reset mid-MULDIV at cnt=30 -> outputs take reset values before the next clk edge, and after release the state is RUN with muldiv_busy=0.
